// File: rtl/mem_lane_rdp.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_rdp
//  Description : Simple dual-port RAM with one write port and one read port on
//                a single clock. Features per-lane write enables, a read
//                latency of 1 or 2, a selectable same-address read-during-write
//                result, and a zero-fill clear engine that runs after reset
//                or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_rdp #(
  parameter int ADDR_WIDTH     = 6,
  parameter int BUS_WIDTH      = 14,
  parameter int LANE_WIDTH     = 7,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  output logic                             busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [BUS_WIDTH/LANE_WIDTH-1:0]  wr_lane,
  input  logic [BUS_WIDTH-1:0]             din,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [BUS_WIDTH-1:0]             dout,
  output logic                             rd_valid
);

  localparam int                    c_lanes     = BUS_WIDTH / LANE_WIDTH;
  localparam int                    c_depth     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [BUS_WIDTH-1:0]    r_mem [c_depth];

  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [BUS_WIDTH-1:0]    w_rd_old;
  logic [BUS_WIDTH-1:0]    w_rd_data;

  // The clear engine owns the array while busy; no port traffic is admitted
  // then, and nothing is admitted during a reset cycle either.
  assign busy     = (r_state == ST_CLEAR);
  assign w_wr_acc = wr_en & ~busy & ~rst;
  assign w_rd_acc = rd_en & ~busy & ~rst;

  // Clear FSM: sweeps clr_cnt from 0 to depth-1 once, never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == c_last_addr) begin
            r_state <= ST_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array write: zero-fill word while clearing, otherwise lane-masked write.
  // A write accepted in the same cycle as clr lands first and is then
  // overwritten by the fill that starts on the following edge.
  always_ff @(posedge clk) begin
    if (busy && !rst) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < c_lanes; i++) begin
        if (wr_lane[i]) begin
          r_mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Pre-write contents of the addressed word.
  assign w_rd_old = r_mem[rd_addr];

  // Same-address read-during-write result selection.
  if (RDW_MODE == 1) begin : g_rdw_old
    assign w_rd_data = w_rd_old;
  end else begin : g_rdw_new
    logic w_hit;
    assign w_hit = w_wr_acc && (wr_addr == rd_addr);
    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
      assign w_rd_data[g*LANE_WIDTH +: LANE_WIDTH] =
        (w_hit && wr_lane[g]) ? din[g*LANE_WIDTH +: LANE_WIDTH]
                              : w_rd_old[g*LANE_WIDTH +: LANE_WIDTH];
    end
    if (c_lanes * LANE_WIDTH < BUS_WIDTH) begin : g_tail
      assign w_rd_data[BUS_WIDTH-1:c_lanes*LANE_WIDTH] =
        w_rd_old[BUS_WIDTH-1:c_lanes*LANE_WIDTH];
    end
  end

  // Read pipeline: one or two register stages; dout holds between valids.
  if (RD_LATENCY == 1) begin : g_lat1
    // Single stage: capture the selected word at the acceptance edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid <= 1'b0;
        dout     <= '0;
      end else begin
        rd_valid <= w_rd_acc;
        if (w_rd_acc) begin
          dout <= w_rd_data;
        end
      end
    end
  end else begin : g_lat2
    logic                 r_p1_valid;
    logic [BUS_WIDTH-1:0] r_p1_data;

    // Two stages: array read register followed by the output register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_p1_valid <= 1'b0;
        r_p1_data  <= '0;
        rd_valid   <= 1'b0;
        dout       <= '0;
      end else begin
        r_p1_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_p1_data <= w_rd_data;
        end
        rd_valid <= r_p1_valid;
        if (r_p1_valid) begin
          dout <= r_p1_data;
        end
      end
    end
  end

endmodule
`default_nettype wire
